// File: rtl/mem_req_arbiter_pkg.sv
// Shared source IDs and transfer-size encodings for the memory request arbiter.
// The macro forms are kept for legacy code that still uses `SRC_* / `SIZE_*.
`ifndef MEM_ARB_COMMON_VH
`define MEM_ARB_COMMON_VH
`define SRC_INST  1'b0
`define SRC_DATA  1'b1
`define SIZE_BYTE 2'd0
`define SIZE_HALF 2'd1
`define SIZE_WORD 2'd2
`endif

package mem_req_arbiter_pkg;
  localparam logic       SRC_INST  = `SRC_INST;
  localparam logic       SRC_DATA  = `SRC_DATA;
  localparam logic [1:0] SIZE_BYTE = `SIZE_BYTE;
  localparam logic [1:0] SIZE_HALF = `SIZE_HALF;
  localparam logic [1:0] SIZE_WORD = `SIZE_WORD;

  function automatic logic other_src(input logic src);
    return (src == SRC_INST) ? SRC_DATA : SRC_INST;
  endfunction
endpackage

// File: rtl/arb_order_fifo.sv
// 1-bit-wide synchronous FIFO recording which source issued each accepted request.
// Push while full and pop while empty are dropped.
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; responses routed in order.
// Define MEM_ARB_RR_EN for round-robin arbitration on conflicts (default: data over inst).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  logic full;
  logic empty;
  logic head_src;
  logic grant_inst;
  logic grant_data;
  logic push;
  logic pop;
  logic push_src;

`ifdef MEM_ARB_RR_EN
  logic rr;

  always_ff @(posedge clk) begin
    if (!resetn)   rr <= SRC_INST;
    else if (push) rr <= other_src(push_src);
  end
`endif

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!full) begin
      if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
        grant_inst = (rr == SRC_INST);
        grant_data = (rr == SRC_DATA);
`else
        grant_data = 1'b1;
`endif
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  always_comb begin
    mem_req   = grant_inst || grant_data;
    mem_wr    = 1'b0;
    mem_size  = SIZE_WORD;
    mem_addr  = inst_addr;
    mem_wdata = '0;
    if (grant_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign push_src     = grant_data ? SRC_DATA : SRC_INST;
  assign push         = mem_req && mem_addr_ok;
  assign pop          = mem_data_ok && !empty;
  assign inst_addr_ok = mem_addr_ok && grant_inst;
  assign data_addr_ok = mem_addr_ok && grant_data;

  // Zero-latency return: the head of the order FIFO steers the response.
  assign inst_data_ok = pop && (head_src == SRC_INST);
  assign data_data_ok = pop && (head_src == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_order_fifo #(.DEPTH(OUTSTANDING)) u_order_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (push_src),
    .dout   (head_src),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios then randomized traffic against
// a queue-based reference model; a decoupled monitor scores every response.
module tb_mem_req_arbiter;
  localparam int OUTSTANDING = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: order of accepted requests, plus scoreboard of expected responses {src, rdata}.
  logic        ord_q[$];
  logic [32:0] exp_q[$];
  logic        model_rr;
  logic        acc_i, acc_d;

  mem_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluated mid-cycle with stable inputs; updates happen as of the next edge.
  always @(negedge clk) begin
    logic want_i, want_d, full, g_i, g_d, src;
    acc_i = inst_addr_ok;
    acc_d = data_addr_ok;
    if (!resetn) begin
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      ord_q.delete();
      model_rr = 1'b0;
    end else begin
      want_i = inst_req;
      want_d = data_req;
      full   = (ord_q.size() == OUTSTANDING);
      g_i = 1'b0;
      g_d = 1'b0;
      if (!full && want_i && want_d) begin
`ifdef MEM_ARB_RR_EN
        if (model_rr == 1'b0) g_i = 1'b1; else g_d = 1'b1;
`else
        g_d = 1'b1;
`endif
      end else if (!full) begin
        g_i = want_i;
        g_d = want_d;
      end
      chk("mem_req", 32'(mem_req), 32'(g_i || g_d));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(g_i && mem_addr_ok));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(g_d && mem_addr_ok));
      if (g_d) begin
        chk("mem_wr_d", 32'(mem_wr), 32'(data_wr));
        chk("mem_size_d", 32'(mem_size), 32'(data_size));
        chk("mem_addr_d", mem_addr, data_addr);
        chk("mem_wdata_d", mem_wdata, data_wdata);
      end else if (g_i) begin
        chk("mem_wr_i", 32'(mem_wr), 32'd0);
        chk("mem_size_i", 32'(mem_size), 32'd2);
        chk("mem_addr_i", mem_addr, inst_addr);
        chk("mem_wdata_i", mem_wdata, 32'd0);
      end
      if (mem_data_ok && ord_q.size() != 0) begin
        src = ord_q.pop_front();
        exp_q.push_back({src, mem_rdata});
      end
      if ((g_i || g_d) && mem_addr_ok) begin
        ord_q.push_back(g_d);
        model_rr = !g_d;
      end
    end
  end

  // Monitor: scores whatever response the DUT presents against the scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    #1;
    if (inst_data_ok || data_data_ok) begin
      if (inst_data_ok && data_data_ok) begin
        checks++; errors++;
        $display("FAIL both_data_ok: got inst=1 data=1 expected one at %0t", $time);
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_data_ok: got inst=%0b data=%0b expected none at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_src", 32'(data_data_ok), 32'(e[32]));
        chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e[31:0]);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL missing_data_ok: got none expected src=%0d rdata=0x%08h at %0t",
               exp_q[0][32], exp_q[0][31:0], $time);
      exp_q.delete();
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic aok, input logic dok, input logic [31:0] rd);
    idle_inputs();
    inst_req = 1; inst_addr = a; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    step();
  endtask

  task automatic resp(input logic [31:0] rd);
    idle_inputs();
    mem_data_ok = 1; mem_rdata = rd;
    step();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    step(); step();
    resetn = 1;
    step();
    // Stray response with empty FIFO must be ignored.
    resp(32'h1111_2222);

    // Single fetch: accepted cycle 1, answered cycle 3.
    fetch(32'hBFC0_0000, 1, 0, 0);
    idle_inputs(); step();
    resp(32'h2408_0001);

    // Conflict: both request a word.
    idle_inputs();
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_1000;
    mem_addr_ok = 1;
    step();
    inst_req = !acc_i; data_req = !acc_d;
    step();
    resp(32'hAAAA_0001);
    resp(32'hAAAA_0002);

    // Back-pressure: fill, stall, pop-with-pending, then push.
    for (int i = 0; i < 6; i++) fetch(32'hBFC0_0100 + 32'(4*i), 1, 0, 0);
    fetch(32'hBFC0_0200, 1, 1, 32'h5555_0000);
    fetch(32'hBFC0_0200, 1, 0, 0);
    for (int i = 0; i < 4; i++) resp(32'h6666_0000 + 32'(i));

    // Interleave I, D-store, I, D-store.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      mem_addr_ok = 1;
      if (i % 2 == 0) begin
        inst_req = 1; inst_addr = 32'hBFC0_0300 + 32'(4*i);
      end else begin
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
      end
      step();
    end
    for (int i = 0; i < 4; i++) resp(32'h7777_0000 + 32'(i));

    // Reset with three outstanding, then a stale response.
    for (int i = 0; i < 3; i++) fetch(32'hBFC0_0400 + 32'(4*i), 1, 0, 0);
    resetn = 0; idle_inputs(); step();
    resetn = 1;
    resp(32'hBAD0_BAD0);
    resp(32'hBAD0_BAD1);

    // Randomized traffic with requester hold semantics.
    for (int n = 0; n < 3000; n++) begin
      int aok_pct, dok_pct;
      aok_pct = ((n / 500) % 2 == 0) ? 80 : 40;
      dok_pct = ((n / 250) % 3 == 0) ? 15 : 55;
      if (!(inst_req && !acc_i)) begin
        inst_req  = ($urandom_range(0, 99) < 60);
        inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!(data_req && !acc_d)) begin
        data_req   = ($urandom_range(0, 99) < 50);
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom();
        data_wdata = $urandom();
      end
      mem_addr_ok = ($urandom_range(0, 99) < aok_pct);
      mem_data_ok = ($urandom_range(0, 99) < dok_pct);
      mem_rdata   = $urandom();
      resetn = ($urandom_range(0, 299) != 0);
      if (!resetn) idle_inputs();
      step();
    end

    resetn = 1;
    idle_inputs();
    for (int i = 0; i < 8; i++) resp($urandom());
    idle_inputs();
    step(); step();
    chk("final_order_empty", 32'(ord_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch channel and the load/store data channel.
- Sits between the fetch/memory stages and the bus bridge.
- Selects one request per cycle and records the source of every accepted request in an order FIFO.
- Routes in-order responses back to the requester that issued them. Adds zero cycles of latency on either path.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered requests (order FIFO depth, power of two, ≥2).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req  in  1  fetch request (read only, word size)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid (load data or store ack)
- data_rdata  out  32  load data
- mem_req  out  1  shared-port request
- mem_wr  out  1  shared-port write
- mem_size  out  2  shared-port size
- mem_addr  out  32  shared-port address
- mem_wdata  out  32  shared-port write data
- mem_addr_ok  in  1  shared port accepted request
- mem_data_ok  in  1  shared port response valid
- mem_rdata  in  32  shared-port read data

Behaviour:
- Single clock clk. Reset is synchronous, active-low, on resetn.
- Reset: FIFO empty, count=0, rr pointer=inst. All *_addr_ok and *_data_ok outputs are combinational and therefore 0 while the FIFO is empty and no requests are present.
- Grant (combinational):
  - full = (count == OUTSTANDING).
  - If full, mem_req=0 and no grant.
  - Otherwise, fixed priority: data over inst.
  - mem_req = (inst_req || data_req) && !full.
- Request mux:
  - Data granted: mem_wr/mem_size/mem_addr/mem_wdata come from the data channel.
  - Inst granted: mem_wr=0, mem_size=2, mem_addr=inst_addr, mem_wdata=0.
- Address handshake:
  - inst_addr_ok = mem_addr_ok && grant_inst.
  - data_addr_ok = mem_addr_ok && grant_data.
  - The non-granted requester sees addr_ok=0 and must hold its request.
  - mem_addr_ok while mem_req=0 is ignored.
- Push: when mem_req && mem_addr_ok, write the source ID (SRC_INST/SRC_DATA) at the write pointer and increment the write pointer modulo OUTSTANDING.
- Pop: when mem_data_ok && count != 0, read the head source, raise the matching *_data_ok for exactly that cycle, and increment the read pointer modulo OUTSTANDING.
- Read data: mem_rdata drives both inst_rdata and data_rdata unconditionally; only the data_ok qualifies it.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push is blocked only by full at the start of the cycle; a same-cycle pop does not unblock it.
- mem_data_ok with count == 0: protocol violation. Ignored: no data_ok, no pointer change.
- The slave never returns data_ok for a request in the same cycle as its addr_ok.
- Cancellation: none. Cancelled fetches still receive inst_data_ok; the fetch stage discards them.
- Reset asserted mid-transaction: FIFO is flushed. The bus bridge is reset in the same cycle, so there are no stale responses.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - A 1-bit rr pointer selects which channel wins when both request.
  - After each accepted request, rr points to the other source.
  - A lone requester always wins regardless of rr.
- Not defined: fixed data-over-inst priority, and the rr register is not built.

Decomposition:
- common.vh holds `SRC_INST (1'b0), `SRC_DATA (1'b1), and the size encodings `SIZE_BYTE/`SIZE_HALF/`SIZE_WORD.
- One sub-module, arb_order_fifo: a 1-bit-wide, OUTSTANDING-deep synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty.
  - Reset: resetn, synchronous, active-low.

Test Plan:
- Reset, idle: resetn=0 for 2 cycles -> mem_req=0, all *_ok=0, count=0; mem_data_ok pulse with FIFO empty -> no data_ok.
- Single fetch: inst_req, addr 0xBFC00000, mem_addr_ok in cycle 1, mem_data_ok in cycle 3 with rdata 0x24080001 -> inst_addr_ok in cycle 1, inst_data_ok=1 and inst_rdata=0x24080001 in cycle 3, data_data_ok=0.
- Conflict: inst_req and data_req (load 0x80001000, size 2) in the same cycle, mem_addr_ok=1 -> data granted first, inst granted next cycle. Responses route in order: data_data_ok, then inst_data_ok. With MEM_ARB_RR_EN and rr=inst: inst wins first.
- Back-pressure: OUTSTANDING=4, issue 4 fetches with no mem_data_ok -> 5th cycle mem_req=0. Pop + pending request in the same cycle -> no push that cycle; push next cycle.
- Interleave: sequence I,D(store 0x80000010 wdata 0xDEADBEEF size 2),I,D accepted; 4 mem_data_ok -> data_ok pattern inst,data,inst,data; mem_wr=1 only for the D pushes.
- Reset mid-flight: 3 outstanding, resetn=0 one cycle -> count=0, following mem_data_ok ignored.
